cg_sweep_misr: RTL and testbench

- Sequential harness stage wrapped around one combinational benchmark netlist from the dataset: an 11-input, 11-output AIG (x0..x10 -> f1..f11).
- Upstream side: it drives every input vector 0 .. 2^N_IN-1 onto the netlist inputs.
- Downstream side: it takes the netlist outputs and compacts them into a MISR signature. It also counts the vectors for which one selected output is 1.
- Used to produce per-circuit golden signatures for the dataset and to check resynthesised variants against them.

---
 rtl/cg_sweep_misr_if.sv | 28 ++
 rtl/cg_sweep_misr.sv | 110 +++++++++++
 tb/tb_cg_sweep_misr.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/cg_sweep_misr_if.sv
// Harness-side bundle for cg_sweep_misr: sweep control, netlist vector/response and MISR results.
// The harness (master) drives control and response; the sweep stage (slave) drives vector and results.
interface cg_sweep_misr_if #(
   parameter int N_IN  = 11,
   parameter int N_OUT = 11,
   parameter int W     = 16
);
   logic              start;
   logic              stall;
   logic [W-1:0]      exp_sig;
   logic [N_IN-1:0]   vec_out;
   logic [N_OUT-1:0]  resp_in;
   logic              busy;
   logic              done;
   logic [W-1:0]      sig;
   logic [N_IN:0]     hit_cnt;
   logic              pass;

   modport master (
      output start, stall, exp_sig, resp_in,
      input  vec_out, busy, done, sig, hit_cnt, pass
   );

   modport slave (
      input  start, stall, exp_sig, resp_in,
      output vec_out, busy, done, sig, hit_cnt, pass
   );
endinterface

// File: rtl/cg_sweep_misr.sv
// Exhaustive input sweep around a combinational netlist, compacting its responses into a MISR
// signature and counting vectors where one selected response bit is set.
//
// state   | meaning
// S_IDLE  | after reset, waiting for start
// S_SWEEP | driving vectors and absorbing responses (frozen while stall)
// S_DONE  | sweep complete, signature and hit count held, pass valid
module cg_sweep_misr #(
   parameter int           N_IN    = 11,
   parameter int           N_OUT   = 11,
   parameter int           W       = 16,
   parameter logic [W-1:0] POLY    = 16'h1021,
   parameter logic [W-1:0] SEED    = 16'hFFFF,
   parameter int           HIT_BIT = 0
) (
   input  logic              clk,
   input  logic              rst,
   cg_sweep_misr_if.slave    bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SWEEP = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   localparam logic [N_IN-1:0] VEC_MAX = {N_IN{1'b1}};

   state_t            state_q, state_d;
   logic [N_IN-1:0]   vec_q,   vec_d;
   logic [W-1:0]      sig_q,   sig_d;
   logic [N_IN:0]     hit_q,   hit_d;
   logic              busy_q,  busy_d;
   logic              done_q,  done_d;

   logic [N_OUT-1:0]  resp;
   logic [W-1:0]      misr_next;

   assign resp      = bus.resp_in;
   assign misr_next = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ W'(resp);

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      sig_d   = sig_q;
      hit_d   = hit_q;
      busy_d  = busy_q;
      done_d  = done_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               state_d = S_SWEEP;
               vec_d   = '0;
               sig_d   = SEED;
               hit_d   = '0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
            end
         end
         S_SWEEP: begin
            // resp_in belongs to the vector on vec_out now, so absorb and advance on one edge
            if (!bus.stall) begin
               sig_d = misr_next;
               hit_d = hit_q + (N_IN+1)'(resp[HIT_BIT]);
               if (vec_q == VEC_MAX) begin
                  state_d = S_DONE;
                  vec_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  vec_d = vec_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            vec_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         vec_q   <= '0;
         sig_q   <= SEED;
         hit_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         sig_q   <= sig_d;
         hit_q   <= hit_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bus.vec_out = vec_q;
   assign bus.sig     = sig_q;
   assign bus.hit_cnt = hit_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   // pass follows exp_sig combinationally so a late-arriving golden value is still judged
   assign bus.pass    = done_q & (sig_q == bus.exp_sig);

endmodule

// File: tb/tb_cg_sweep_misr.sv
// Bench for cg_sweep_misr: table of sweep scenarios over several response functions, checked
// against a plain-arithmetic signature/hit model, plus reset and restart sequences.
module tb_cg_sweep_misr;

   localparam int NV = 2048;

   logic clk;
   logic rst;
   int   mode_r;
   int   n_chk;
   int   n_fail;
   logic [10:0] resp_tab [NV];

   cg_sweep_misr_if #(.N_IN(11), .N_OUT(11), .W(16)) bus ();

   cg_sweep_misr #(
      .N_IN(11), .N_OUT(11), .W(16), .POLY(16'h1021), .SEED(16'hFFFF), .HIT_BIT(0)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // netlist stand-in: response is a pure function of the current vector
   always_comb begin
      case (mode_r)
         0:       bus.resp_in = '0;
         1:       bus.resp_in = {11{~bus.vec_out[7] | bus.vec_out[8]}};
         2:       bus.resp_in = resp_tab[bus.vec_out];
         default: bus.resp_in = bus.vec_out ^ {3'b000, bus.vec_out[10:3]};
      endcase
   end

   typedef struct {
      int mode;
      int stall_at;   // -1 none, -2 stall raised together with start
      int stall_len;
      int start_at;   // -1 none
      int exp_edges;
   } sweep_t;

   sweep_t tab [7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int resp_of(input int mode, input int v);
      case (mode)
         0:       return 0;
         1:       return (((v >> 7) & 1) == 0 || ((v >> 8) & 1) == 1) ? 'h7FF : 0;
         2:       return int'(resp_tab[v]);
         default: return (v ^ (v >> 3)) & 'h7FF;
      endcase
   endfunction

   task automatic model(input int mode, output logic [15:0] s_out, output int h);
      int s;
      int r;
      s = 'hFFFF;
      h = 0;
      for (int v = 0; v < NV; v++) begin
         r = resp_of(mode, v);
         s = ((s * 2) % 65536) ^ ((s >= 32768) ? 'h1021 : 0) ^ r;
         h = h + (r % 2);
      end
      s_out = s[15:0];
   endtask

   task automatic run_sweep(input sweep_t t, input string tag);
      logic [15:0] msig;
      int mhit;
      int n, rem, bad, hold_val, prev;
      bit st_used, sp_used, sp_clear;
      model(t.mode, msig, mhit);
      @(negedge clk);
      mode_r   = t.mode;
      bus.start = 1'b1;
      rem = 0; st_used = 0; sp_used = 0; sp_clear = 0; hold_val = t.stall_at;
      if (t.stall_at == -2) begin
         bus.stall = 1'b1;
         rem       = t.stall_len + 1;
         st_used   = 1;
         hold_val  = 0;
      end
      @(posedge clk);
      #1;
      chk({tag, "_start_edge"}, {bus.busy, bus.done, bus.pass, bus.vec_out, bus.sig, bus.hit_cnt},
          {1'b1, 1'b0, 1'b0, 11'd0, 16'hFFFF, 12'd0});
      @(negedge clk);
      bus.start = 1'b0;
      n = 0; bad = 0; prev = 0;
      while (!bus.done && n < 6000) begin
         if (rem > 0) begin
            if (int'(bus.vec_out) != hold_val) bad++;
            rem--;
            if (rem == 0) bus.stall = 1'b0;
         end else if (!st_used && int'(bus.vec_out) == t.stall_at) begin
            bus.stall = 1'b1;
            rem       = t.stall_len;
            st_used   = 1;
         end
         if (sp_clear) begin
            bus.start = 1'b0;
            sp_clear  = 0;
         end else if (!sp_used && int'(bus.vec_out) == t.start_at) begin
            bus.start = 1'b1;
            sp_used   = 1;
            sp_clear  = 1;
         end
         if (int'(bus.vec_out) != prev && int'(bus.vec_out) != prev + 1) bad++;
         if (!bus.busy) bad++;
         prev = int'(bus.vec_out);
         @(posedge clk);
         n++;
         @(negedge clk);
      end
      bus.start = 1'b0;
      bus.stall = 1'b0;
      chk({tag, "_done_edge"}, 64'(n), 64'(t.exp_edges));
      chk({tag, "_progress_errs"}, 64'(bad), 64'd0);
      chk({tag, "_sig"}, 64'(bus.sig), 64'(msig));
      chk({tag, "_hit"}, 64'(bus.hit_cnt), 64'(mhit));
      if (t.mode == 1) chk({tag, "_hit_f1"}, 64'(bus.hit_cnt), 64'd1536);
      chk({tag, "_done_outs"}, {bus.busy, bus.vec_out}, {1'b0, 11'd0});
      bus.exp_sig = msig;
      #1;
      chk({tag, "_pass_hi"}, 64'(bus.pass), 64'd1);
      bus.exp_sig = msig ^ 16'h0001;
      #1;
      chk({tag, "_pass_lo"}, 64'(bus.pass), 64'd0);
      bus.exp_sig = msig;
   endtask

   initial begin
      int n;
      n_chk = 0; n_fail = 0;
      mode_r = 0;
      rst = 1'b0;
      bus.start = 1'b0;
      bus.stall = 1'b0;
      bus.exp_sig = 16'h0000;
      for (int i = 0; i < NV; i++) resp_tab[i] = 11'($urandom);

      tab[0] = '{0, -1, 0, -1, 2048};
      tab[1] = '{1, -1, 0, -1, 2048};
      tab[2] = '{1, 100, 5, -1, 2053};
      tab[3] = '{2, -1, 0, 500, 2048};
      tab[4] = '{3, 777, 3, -1, 2051};
      tab[5] = '{2, -2, 2, -1, 2050};
      tab[6] = '{2, -1, 0, -1, 2048};

      #1 rst = 1'b1;
      #1;
      chk("reset_state", {bus.busy, bus.done, bus.pass, bus.vec_out, bus.sig, bus.hit_cnt},
          {1'b0, 1'b0, 1'b0, 11'd0, 16'hFFFF, 12'd0});
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) run_sweep(tab[i], $sformatf("run%0d", i));

      // asynchronous reset in the middle of a sweep
      @(negedge clk);
      mode_r = 2;
      bus.start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (bus.vec_out != 11'd1200 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("reach_1200", 64'(bus.vec_out), 64'd1200);
      #2 rst = 1'b1;
      #1;
      chk("midreset_outs", {bus.busy, bus.done, bus.pass, bus.vec_out, bus.sig, bus.hit_cnt},
          {1'b0, 1'b0, 1'b0, 11'd0, 16'hFFFF, 12'd0});
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("idle_after_reset", {bus.busy, bus.done, bus.vec_out, bus.sig}, {1'b0, 1'b0, 11'd0, 16'hFFFF});

      run_sweep(tab[6], "post_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
